soc_flr_port_sequencer: RTL and testbench

SOC_FLR_PORT_SEQUENCER -- requirements
Module: soc_flr_port_sequencer

---
 rtl/soc_flr_seq_pkg.sv | 37 +++
 rtl/soc_flr_port_sequencer.sv | 177 +++++++++++++++++
 tb/tb_soc_flr_port_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/soc_flr_seq_pkg.sv
// ----------------------------------------------------------------------------
// soc_flr_seq_pkg
// Shared types and helpers for the FLR port sequencer.
//   t_flr_state  : sequencer FSM state encoding
//   t_port_idx   : AFU top router port index
//   PORT_*       : port index constants (ST2MM/PF0, port gasket/PF0 VFs,
//                  static region/PF1+)
//   map_flr_port : request -> target port mapping
// ----------------------------------------------------------------------------
package soc_flr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    CPL   = 2'd3
  } t_flr_state;

  typedef logic [1:0] t_port_idx;

  localparam t_port_idx PORT_ST2MM = 2'd0;
  localparam t_port_idx PORT_PG    = 2'd1;
  localparam t_port_idx PORT_SR    = 2'd2;

  // The PF width is a parameter of the sequencer, so the caller reduces the
  // PF number to a single "is PF0" flag before mapping.
  function automatic t_port_idx map_flr_port(input logic pf_is_zero,
                                             input logic vf_active);
    if (!pf_is_zero) begin
      return PORT_SR;
    end else if (vf_active) begin
      return PORT_PG;
    end
    return PORT_ST2MM;
  endfunction

endpackage : soc_flr_seq_pkg

// File: rtl/soc_flr_port_sequencer.sv
// ----------------------------------------------------------------------------
// soc_flr_port_sequencer
// Sequences one Function Level Reset at a time: accepts an FLR request,
// waits for the owning AFU router port to drain (bounded by a timeout),
// holds that port in reset for HOLD_CYCLES cycles, then returns a
// completion carrying the original PF/VF identity.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   flr_req_*           : FLR request channel (valid/ready handshake)
//   port_busy           : per-port "transactions outstanding" indication
//   port_rst_n          : per-port active-low reset output
//   flr_cpl_*           : FLR completion channel (valid/ready handshake)
//   drain_timeout_err   : one-cycle pulse when the drain wait gives up
// ----------------------------------------------------------------------------
module soc_flr_port_sequencer
  import soc_flr_seq_pkg::*;
#(
  parameter int NUM_PORTS     = 3,
  parameter int PF_WIDTH      = 3,
  parameter int VF_WIDTH      = 11,
  parameter int HOLD_CYCLES   = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 flr_req_valid,
  output logic                 flr_req_ready,
  input  logic [PF_WIDTH-1:0]  flr_req_pf,
  input  logic [VF_WIDTH-1:0]  flr_req_vf,
  input  logic                 flr_req_vf_active,

  input  logic [NUM_PORTS-1:0] port_busy,
  output logic [NUM_PORTS-1:0] port_rst_n,

  output logic                 flr_cpl_valid,
  input  logic                 flr_cpl_ready,
  output logic [PF_WIDTH-1:0]  flr_cpl_pf,
  output logic [VF_WIDTH-1:0]  flr_cpl_vf,
  output logic                 flr_cpl_vf_active,

  output logic                 drain_timeout_err
);

  // One counter serves both the drain wait and the reset hold, so it is
  // sized for the larger of the two; it is cleared on every state entry and
  // never counts past its terminal value, so it cannot wrap.
  localparam int CNT_MAX = (HOLD_CYCLES > DRAIN_TIMEOUT) ? HOLD_CYCLES : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  t_flr_state           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  t_port_idx            target_q;
  logic [PF_WIDTH-1:0]  pf_q;
  logic [VF_WIDTH-1:0]  vf_q;
  logic                 vf_active_q;
  logic                 req_ready_q;
  logic [NUM_PORTS-1:0] port_rst_n_q, port_rst_n_d;
  logic                 req_accept;
  logic                 target_busy;
  logic                 timeout_hit;

  assign req_accept  = flr_req_valid && req_ready_q;
  assign target_busy = port_busy[target_q];

  // --------------------------------------------------------------------------
  // Next-state / counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_hit  = 1'b0;
    port_rst_n_d = '1;

    unique case (state_q)
      IDLE: begin
        if (req_accept) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end

      DRAIN: begin
        // An idle port wins over a coincident timeout.
        if (!target_busy) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          timeout_hit = 1'b1;
          state_d     = HOLD;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        // port_busy is deliberately not looked at here.
        if (cnt_q == HOLD_LAST) begin
          state_d = CPL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CPL: begin
        if (flr_cpl_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Port reset follows the state being entered, so the registered output
    // drops on the edge into HOLD and rises on the edge into CPL.
    if (state_d == HOLD) begin
      port_rst_n_d[target_q] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State, counter and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: port resets are held asserted (all 0) while the sequencer itself
      // is in reset, and only released by the first clock after rst_n rises.
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      port_rst_n_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == IDLE);
      port_rst_n_q <= port_rst_n_d;
    end
  end

  // Request identity is captured on the accept edge and held through CPL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q    <= PORT_ST2MM;
      pf_q        <= '0;
      vf_q        <= '0;
      vf_active_q <= 1'b0;
    end else if (req_accept) begin
      target_q    <= map_flr_port(flr_req_pf == '0, flr_req_vf_active);
      pf_q        <= flr_req_pf;
      vf_q        <= flr_req_vf;
      vf_active_q <= flr_req_vf_active;
    end
  end

  assign flr_req_ready     = req_ready_q;
  assign port_rst_n        = port_rst_n_q;
  assign flr_cpl_valid     = (state_q == CPL);
  assign flr_cpl_pf        = pf_q;
  assign flr_cpl_vf        = vf_q;
  assign flr_cpl_vf_active = vf_active_q;
  assign drain_timeout_err = timeout_hit;

endmodule : soc_flr_port_sequencer

// File: tb/tb_soc_flr_port_sequencer.sv
// ----------------------------------------------------------------------------
// tb_soc_flr_port_sequencer
// Directed self-checking bench for soc_flr_port_sequencer with default
// parameters (3 ports, HOLD_CYCLES=16, DRAIN_TIMEOUT=1024).
// Cycle numbering: the accept edge is edge 0; "cycle c" is the interval
// between edge c-1 and edge c, sampled 1 time unit after edge c-1.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_soc_flr_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flr_req_valid;
  logic        flr_req_ready;
  logic [2:0]  flr_req_pf;
  logic [10:0] flr_req_vf;
  logic        flr_req_vf_active;
  logic [2:0]  port_busy;
  logic [2:0]  port_rst_n;
  logic        flr_cpl_valid;
  logic        flr_cpl_ready;
  logic [2:0]  flr_cpl_pf;
  logic [10:0] flr_cpl_vf;
  logic        flr_cpl_vf_active;
  logic        drain_timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  soc_flr_port_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flr_req_valid     (flr_req_valid),
    .flr_req_ready     (flr_req_ready),
    .flr_req_pf        (flr_req_pf),
    .flr_req_vf        (flr_req_vf),
    .flr_req_vf_active (flr_req_vf_active),
    .port_busy         (port_busy),
    .port_rst_n        (port_rst_n),
    .flr_cpl_valid     (flr_cpl_valid),
    .flr_cpl_ready     (flr_cpl_ready),
    .flr_cpl_pf        (flr_cpl_pf),
    .flr_cpl_vf        (flr_cpl_vf),
    .flr_cpl_vf_active (flr_cpl_vf_active),
    .drain_timeout_err (drain_timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, checks it is acceptable, and lets the accept edge
  // pass; returns in cycle 1 with valid still high (caller decides).
  task automatic send_req(input string tag, input logic [2:0] pf,
                          input logic [10:0] vf, input logic vfa);
    flr_req_valid     = 1'b1;
    flr_req_pf        = pf;
    flr_req_vf        = vf;
    flr_req_vf_active = vfa;
    check({tag, "_ready_before_accept"}, flr_req_ready, 1'b1);
    tick();
  endtask

  int err_pulses;
  int err_cycle;
  int cpl_seen;

  initial begin
    rst_n             = 1'b0;
    flr_req_valid     = 1'b0;
    flr_req_pf        = '0;
    flr_req_vf        = '0;
    flr_req_vf_active = 1'b0;
    port_busy         = '0;
    flr_cpl_ready     = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_port_rst_n", port_rst_n, 3'b000);
    check("rst_req_ready", flr_req_ready, 1'b0);
    check("rst_cpl_valid", flr_cpl_valid, 1'b0);
    check("rst_timeout_err", drain_timeout_err, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    check("rel_port_rst_n", port_rst_n, 3'b111);
    check("rel_req_ready", flr_req_ready, 1'b1);

    // ---------------- PF0 physical function, port idle ----------------
    err_pulses = 0;
    send_req("t1", 3'd0, 11'd0, 1'b0);
    flr_req_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      check("t1_port_rst_n", port_rst_n, (c >= 2 && c <= 17) ? 3'b110 : 3'b111);
      check("t1_cpl_valid", flr_cpl_valid, (c == 18) ? 1'b1 : 1'b0);
      check("t1_req_ready", flr_req_ready, 1'b0);
      if (drain_timeout_err) err_pulses++;
      if (c == 18) begin
        check("t1_cpl_pf", flr_cpl_pf, 3'd0);
        check("t1_cpl_vf_active", flr_cpl_vf_active, 1'b0);
      end
      if (c < 18) tick();
    end
    check("t1_no_timeout", err_pulses, 0);
    tick();
    check("t1_back_idle_ready", flr_req_ready, 1'b1);
    check("t1_back_idle_cpl", flr_cpl_valid, 1'b0);

    // ---------------- PF0 VF5, port 1 busy for 40 cycles ----------------
    port_busy = 3'b010;
    send_req("t2", 3'd0, 11'd5, 1'b1);
    flr_req_valid = 1'b0;
    for (int c = 1; c <= 57; c++) begin
      if (c == 40) port_busy = 3'b000;
      check("t2_port_rst_n", port_rst_n, (c >= 41 && c <= 56) ? 3'b101 : 3'b111);
      check("t2_cpl_valid", flr_cpl_valid, (c == 57) ? 1'b1 : 1'b0);
      if (c == 57) begin
        check("t2_cpl_pf", flr_cpl_pf, 3'd0);
        check("t2_cpl_vf", flr_cpl_vf, 11'd5);
        check("t2_cpl_vf_active", flr_cpl_vf_active, 1'b1);
      end
      if (c < 57) tick();
    end
    tick();

    // ---------------- PF2, port 2 stuck busy -> drain timeout ----------------
    err_pulses = 0;
    err_cycle  = -1;
    port_busy  = 3'b100;
    send_req("t3", 3'd2, 11'd0, 1'b0);
    flr_req_valid = 1'b0;
    for (int c = 1; c <= 1041; c++) begin
      if (drain_timeout_err) begin
        err_pulses++;
        err_cycle = c;
      end
      if (c == 1024 || c == 1041) check("t3_port_rst_n_released", port_rst_n, 3'b111);
      if (c == 1025 || c == 1040) check("t3_port_rst_n_held", port_rst_n, 3'b011);
      if (c == 1041) begin
        check("t3_cpl_valid", flr_cpl_valid, 1'b1);
        check("t3_cpl_pf", flr_cpl_pf, 3'd2);
      end
      if (c < 1041) tick();
    end
    check("t3_timeout_pulses", err_pulses, 1);
    check("t3_timeout_cycle", err_cycle, 1024);
    tick();
    port_busy = 3'b000;

    // ---------------- back-pressured completion and pending request ----------------
    flr_cpl_ready = 1'b0;
    send_req("t4a", 3'd1, 11'd7, 1'b0);
    // Request B stays valid from here on; it must not be taken until IDLE.
    flr_req_pf        = 3'd0;
    flr_req_vf        = 11'd3;
    flr_req_vf_active = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      if (c == 28) flr_cpl_ready = 1'b1;
      if (c <= 28) begin
        check("t4_req_ready_low", flr_req_ready, 1'b0);
        check("t4_cpl_valid", flr_cpl_valid, (c >= 18) ? 1'b1 : 1'b0);
      end
      if (c == 3) check("t4_port2_reset", port_rst_n, 3'b011);
      if (c >= 18 && c <= 28) begin
        check("t4_cpl_pf_stable", flr_cpl_pf, 3'd1);
        check("t4_cpl_vf_stable", flr_cpl_vf, 11'd7);
        check("t4_cpl_vfa_stable", flr_cpl_vf_active, 1'b0);
      end
      if (c == 29) begin
        check("t4_b_ready", flr_req_ready, 1'b1);
        check("t4_cpl_done", flr_cpl_valid, 1'b0);
      end
      tick();
    end
    // Now in cycle 1 of request B.
    flr_req_valid = 1'b0;
    check("t4b_accepted", flr_req_ready, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      if (c == 2) check("t4b_port1_reset", port_rst_n, 3'b101);
      if (c == 18) begin
        check("t4b_cpl_valid", flr_cpl_valid, 1'b1);
        check("t4b_cpl_vf", flr_cpl_vf, 11'd3);
        check("t4b_cpl_vfa", flr_cpl_vf_active, 1'b1);
      end
      if (c < 18) tick();
    end
    tick();

    // ---------------- reset during HOLD ----------------
    send_req("t5", 3'd0, 11'd0, 1'b0);
    flr_req_valid = 1'b0;
    repeat (4) tick();
    check("t5_in_hold", port_rst_n, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_port_rst_n", port_rst_n, 3'b000);
    check("t5_async_cpl_valid", flr_cpl_valid, 1'b0);
    check("t5_async_req_ready", flr_req_ready, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("t5_rel_port_rst_n", port_rst_n, 3'b111);
    check("t5_rel_req_ready", flr_req_ready, 1'b1);
    cpl_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (flr_cpl_valid) cpl_seen++;
      tick();
    end
    check("t5_no_completion", cpl_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_soc_flr_port_sequencer
